// File: rtl/pipelined_cla_adder_pkg.sv
// rtl/pipelined_cla_adder_pkg.sv - shared parameters and look-ahead helpers for the pipelined CLA adder
package cla_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;
  // Upper bound on group count so the carry helper can use fixed-width vectors
  localparam int MAX_NG    = 64;

  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

  // Second-level carries C[0..ng] from group (P,G), each carry a flat sum of products
  function automatic logic [MAX_NG:0] lookahead_carries(
    input logic [MAX_NG-1:0] grp_p,
    input logic [MAX_NG-1:0] grp_g,
    input logic              c0,
    input int                ng
  );
    logic [MAX_NG:0] c;
    logic            term;
    c    = '0;
    term = 1'b0;
    c[0] = c0;
    for (int k = 0; k < MAX_NG; k++) begin
      if (k < ng) begin
        term = c0;
        for (int m = 0; m <= k; m++) term = term & grp_p[m];
        c[k+1] = term;
        for (int j = 0; j <= k; j++) begin
          term = grp_g[j];
          for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
          c[k+1] = c[k+1] | term;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for the pipelined CLA adder
interface pipelined_cla_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_cla_adder_group.sv
// rtl/pipelined_cla_adder_group.sv - GROUP-bit look-ahead block producing sum bits and group P/G
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] i_p,
  input  logic [GROUP-1:0] i_g,
  input  logic             i_ci,
  output logic [GROUP-1:0] o_sum,
  output logic             o_pg,
  output logic             o_gg
);

  logic [GROUP-1:0] w_pp;
  logic [GROUP-1:0] w_gen;
  logic [GROUP-1:0] w_c;
  logic             w_term;

  // Prefix propagate/generate per bit position, then flat carries: c[k+1] = gen[k] | pp[k]&ci
  always_comb begin
    w_pp   = '0;
    w_gen  = '0;
    w_c    = '0;
    w_term = 1'b0;
    for (int k = 0; k < GROUP; k++) begin
      w_term = 1'b1;
      for (int m = 0; m <= k; m++) w_term = w_term & i_p[m];
      w_pp[k] = w_term;
      for (int j = 0; j <= k; j++) begin
        w_term = i_g[j];
        for (int m = j + 1; m <= k; m++) w_term = w_term & i_p[m];
        w_gen[k] = w_gen[k] | w_term;
      end
    end
    w_c[0] = i_ci;
    for (int k = 0; k < GROUP - 1; k++) w_c[k+1] = w_gen[k] | (w_pp[k] & i_ci);
  end

  assign o_sum = i_p ^ w_c;
  assign o_pg  = w_pp[GROUP-1];
  assign o_gg  = w_gen[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - two-stage pipelined CLA adder/subtractor with valid/ready on both sides
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int NG = num_groups(WIDTH, GROUP);

  logic [WIDTH-1:0] w_bm, w_p, w_g;
  logic             w_c0;
  logic [NG-1:0]    w_grp_p, w_grp_g;
  logic [WIDTH-1:0] w_unused_s1_sum;
  logic             w_out_load, w_s1_load, w_accept;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p, r_g;
  logic [NG-1:0]    r_grp_p, r_grp_g;
  logic             r_c0, r_a_msb, r_bm_msb;

  logic [NG:0]           w_carry;
  logic [MAX_NG-NG-1:0]  w_unused_pad;
  logic [WIDTH-1:0]      w_sum;
  logic [NG-1:0]         w_unused_s2_p, w_unused_s2_g;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero;

  // Subtract is a + ~b + 1 - cin, so the effective carry-in flips with sub
  assign w_bm = bus.sub ? ~bus.b : bus.b;
  assign w_p  = bus.a ^ w_bm;
  assign w_g  = bus.a & w_bm;
  assign w_c0 = bus.cin ^ bus.sub;

  // Both stages shift when the output slot is free or being drained
  assign w_out_load   = !r_out_valid || bus.out_ready;
  assign w_s1_load    = !r_s1_valid || w_out_load;
  assign w_accept     = bus.in_valid && w_s1_load;
  assign bus.in_ready = w_s1_load;

  // Stage-1 groups feed P/G forward; stage-2 groups turn registered p/g plus group carry into sum
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_s1 (
      .i_p   (w_p[k*GROUP +: GROUP]),
      .i_g   (w_g[k*GROUP +: GROUP]),
      .i_ci  (1'b0),
      .o_sum (w_unused_s1_sum[k*GROUP +: GROUP]),
      .o_pg  (w_grp_p[k]),
      .o_gg  (w_grp_g[k])
    );
    cla_group #(.GROUP(GROUP)) u_s2 (
      .i_p   (r_p[k*GROUP +: GROUP]),
      .i_g   (r_g[k*GROUP +: GROUP]),
      .i_ci  (w_carry[k]),
      .o_sum (w_sum[k*GROUP +: GROUP]),
      .o_pg  (w_unused_s2_p[k]),
      .o_gg  (w_unused_s2_g[k])
    );
  end

  assign {w_unused_pad, w_carry} = lookahead_carries(MAX_NG'(r_grp_p), MAX_NG'(r_grp_g), r_c0, NG);

  // Stage 1: capture per-bit and per-group propagate/generate of an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_grp_p    <= '0;
      r_grp_g    <= '0;
      r_c0       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_bm_msb   <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_p      <= w_p;
        r_g      <= w_g;
        r_grp_p  <= w_grp_p;
        r_grp_g  <= w_grp_g;
        r_c0     <= w_c0;
        r_a_msb  <= bus.a[WIDTH-1];
        r_bm_msb <= w_bm[WIDTH-1];
      end
    end
  end

  // Stage 2: register result and flags; everything holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[NG];
        r_ovf  <= (r_a_msb == r_bm_msb) && (w_sum[WIDTH-1] != r_a_msb);
        r_zero <= (w_sum == '0);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for the pipelined CLA adder (16-bit and 8-bit instances)
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  typedef logic [18:0] res_t; // {cout, ovf, zero, sum[15:0]}

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t q16[$];
  res_t q8[$];
  logic stall16_prev = 1'b0;
  logic stall8_prev  = 1'b0;
  res_t obs16_prev   = '0;
  res_t obs8_prev    = '0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) if16 ();
  pipelined_cla_adder_if #(.WIDTH(8))  if8 ();

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  pipelined_cla_adder #(.WIDTH(8),  .GROUP(4)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical add/subtract
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    longint m  = longint'(1) << w;
    longint ua = longint'(a) & (m - 1);
    longint ub = longint'(b) & (m - 1);
    longint ci = longint'(cin);
    longint r  = sub ? (ua - ub - ci) : (ua + ub + ci);
    longint s  = r & (m - 1);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint sr = sub ? (sa - sb - ci) : (sa + sb + ci);
    logic   co = sub ? (r >= 0) : (r >= m);
    logic   ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {co, ov, (s == 0), 16'(s)};
  endfunction

  function automatic res_t obs16();
    return {if16.cout, if16.ovf, if16.zero, if16.sum};
  endfunction

  function automatic res_t obs8();
    return {if8.cout, if8.ovf, if8.zero, 8'h00, if8.sum};
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] msk;
    msk = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return msk;
      2:       return msk >> 1;
      3:       return (msk >> 1) + 16'd1;
      default: return 16'($urandom) & msk;
    endcase
  endfunction

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
    if16.in_valid = v; if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
  endtask

  // Called just after a negedge with inputs settled: score the output beat and log the accepted one
  task automatic eval16();
    #1;
    if (stall16_prev) chk("stall16_hold", obs16(), obs16_prev);
    if (if16.out_valid && if16.out_ready) begin
      chk("beat16_expected", 32'(q16.size() > 0), 32'd1);
      if (q16.size() > 0) chk("data16", obs16(), q16.pop_front());
    end
    if (if16.in_valid && if16.in_ready) q16.push_back(model(16, if16.a, if16.b, if16.cin, if16.sub));
    stall16_prev = if16.out_valid && !if16.out_ready;
    obs16_prev   = obs16();
  endtask

  task automatic eval8();
    #1;
    if (stall8_prev) chk("stall8_hold", obs8(), obs8_prev);
    if (if8.out_valid && if8.out_ready) begin
      chk("beat8_expected", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) chk("data8", obs8(), q8.pop_front());
    end
    if (if8.in_valid && if8.in_ready)
      q8.push_back(model(8, {8'h00, if8.a}, {8'h00, if8.b}, if8.cin, if8.sub));
    stall8_prev = if8.out_valid && !if8.out_ready;
    obs8_prev   = obs8();
  endtask

  // One isolated beat: checks acceptance, exact 2-cycle latency and the expected result
  task automatic single16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input res_t exp);
    if16.out_ready = 1'b1;
    drive16(1'b1, a, b, cin, sub);
    #1 chk({tag, "_in_ready"}, 32'(if16.in_ready), 32'd1);
    @(negedge clk);
    if16.in_valid = 1'b0;
    #1 chk({tag, "_lat1_valid"}, 32'(if16.out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2_valid"}, 32'(if16.out_valid), 32'd1);
    chk({tag, "_result"}, obs16(), exp);
    @(negedge clk);
    #1 chk({tag, "_drained"}, 32'(if16.out_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ta, tb;
    rst = 1'b1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    if16.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
    if8.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_out_valid16", 32'(if16.out_valid), 32'd0);
    chk("rst_flags_sum16", obs16(), 19'h0);
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready16", 32'(if16.in_ready), 32'd1);
    chk("rst_in_ready8", 32'(if8.in_ready), 32'd1);
    @(negedge clk);

    single16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    single16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
    single16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    single16("sub_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 16'h0001});
    single16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});
    single16("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5556});

    // Backpressure: two beats buffer, third is refused until the consumer drains
    if16.out_ready = 1'b0;
    drive16(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
    #1 chk("bp_in_ready_1", 32'(if16.in_ready), 32'd1);
    @(negedge clk);
    drive16(1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
    #1 chk("bp_in_ready_2", 32'(if16.in_ready), 32'd1);
    @(negedge clk);
    drive16(1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
    #1 chk("bp_in_ready_full", 32'(if16.in_ready), 32'd0);
    chk("bp_first_out", obs16(), {3'b000, 16'h0002});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("bp_hold_in_ready", 32'(if16.in_ready), 32'd0);
      chk("bp_hold_valid", 32'(if16.out_valid), 32'd1);
      chk("bp_hold_result", obs16(), {3'b000, 16'h0002});
    end
    @(negedge clk);
    if16.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(if16.in_ready), 32'd1);
    chk("bp_out_0002", obs16(), {3'b000, 16'h0002});
    @(negedge clk);
    if16.in_valid = 1'b0;
    #1 chk("bp_valid_0004", 32'(if16.out_valid), 32'd1);
    chk("bp_out_0004", obs16(), {3'b000, 16'h0004});
    @(negedge clk);
    #1 chk("bp_valid_0006", 32'(if16.out_valid), 32'd1);
    chk("bp_out_0006", obs16(), {3'b000, 16'h0006});
    @(negedge clk);
    #1 chk("bp_empty", 32'(if16.out_valid), 32'd0);
    @(negedge clk);

    // Reset with two beats in flight: neither may ever appear
    if16.out_ready = 1'b1;
    drive16(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'h3333, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    if16.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_valid", 32'(if16.out_valid), 32'd0);
    chk("mid_rst_result", obs16(), 19'h0);
    chk("mid_rst_in_ready", 32'(if16.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("mid_rst_no_beat", 32'(if16.out_valid), 32'd0);
    end
    @(negedge clk);

    // Random 16-bit stream with random stalls
    stall16_prev = 1'b0;
    for (int i = 0; i < 800; i++) begin
      ta = pick(16); tb = pick(16);
      drive16($urandom_range(0, 3) != 0, ta, tb, 1'($urandom), 1'($urandom));
      if16.out_ready = 1'($urandom);
      eval16();
      @(negedge clk);
    end
    if16.in_valid = 1'b0; if16.out_ready = 1'b1;
    for (int i = 0; i < 10 && q16.size() > 0; i++) begin
      eval16();
      @(negedge clk);
    end
    chk("drain16_empty", 32'(q16.size()), 32'd0);

    // 8-bit full-rate burst: one beat per cycle with out_ready held high
    if8.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ta = pick(8); tb = pick(8);
      if8.in_valid = 1'b1; if8.a = ta[7:0]; if8.b = tb[7:0];
      if8.cin = 1'($urandom); if8.sub = 1'($urandom);
      eval8();
      chk("burst8_in_ready", 32'(if8.in_ready), 32'd1);
      if (i >= 2) chk("burst8_out_valid", 32'(if8.out_valid), 32'd1);
      @(negedge clk);
    end

    // 8-bit random stream with random valid and stalls
    for (int i = 0; i < 3000; i++) begin
      ta = pick(8); tb = pick(8);
      if8.in_valid = ($urandom_range(0, 3) != 0); if8.a = ta[7:0]; if8.b = tb[7:0];
      if8.cin = 1'($urandom); if8.sub = 1'($urandom);
      if8.out_ready = 1'($urandom);
      eval8();
      @(negedge clk);
    end
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    for (int i = 0; i < 10 && q8.size() > 0; i++) begin
      eval8();
      @(negedge clk);
    end
    chk("drain8_empty", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
